usb_tx_encoder: RTL and testbench
=================================

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 n_rst  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  bit-time strobe, one clk wide; line state may change only on a clk edge where en=1.
REQ-004 tx_data  input  8  byte to transmit; sent LSB first.
REQ-005 tx_valid  input  1  tx_data and tx_last are valid.
REQ-006 tx_last  input  1  the accepted byte is the final byte of the packet.
REQ-007 tx_ready  output  1  holding register is empty; a byte is accepted on the clk edge where tx_valid=1 and tx_ready=1.
REQ-008 dp_out, dm_out  output  1 each  registered line drive: J=(1,0), K=(0,1), SE0=(0,0); (1,1) is never driven.
REQ-009 tx_busy  output  1  high in every state except IDLE.
REQ-010 tx_done  output  1  one-clk pulse when EOP completes.
REQ-011 tx_error  output  1  one-clk pulse on underrun.

Function
REQ-012 The FSM shall have the states IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
REQ-013 The datapath shall have one 8-bit holding register, one 8-bit shift register with a 3-bit bit index, and a 3-bit ones counter.
- tx_ready = holding register empty, forced to 0 in EOP_SE0/EOP_J.
REQ-014 IDLE: line=J.
- On acceptance, the byte enters the holding register.
- The next en edge leaves IDLE to SYNC (macro on) or DATA (macro off), and the first bit is driven on that edge.
REQ-015 The shift register shall load from the holding register on the en edge that starts its first bit, freeing the holding register.
- Accept and load on the same clk: the load wins, and the new byte is written to the holding register.
REQ-016 NRZI: data bit 0 toggles J/K, data bit 1 holds the current level; NRZI state starts at J for every packet.
REQ-017 Bit stuffing: the ones counter increments on each transmitted 1 and clears on each transmitted 0 or stuffed bit.
- When the count reaches 6, the next bit time is a STUFF state that drives a 0 (toggle) without advancing the bit index.
REQ-018 Stuffing applies across byte boundaries, across the SYNC/DATA boundary, and after the last data bit: a pending stuff bit is sent before EOP.
REQ-019 After bit 7 of a byte with tx_last=1 (and any pending stuff bit), the block shall enter EOP_SE0 for 2 bit times, then EOP_J for 1 bit time, then IDLE with a tx_done pulse.
REQ-020 Underrun: bit 7 of a non-last byte ends with the holding register empty.
- The block shall pulse tx_error and proceed directly to EOP_SE0 (no stuff bit); tx_done still pulses at the end.
REQ-021 tx_valid while tx_ready=0 shall be ignored: no data loss, and the sender must hold.
REQ-022 Outputs shall not change between en strobes; en=1 in IDLE with no byte accepted leaves everything at reset values.

Reset
REQ-023 n_rst low shall immediately force:
- state=IDLE, dp_out=1, dm_out=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0;
- holding register empty, ones counter 0, NRZI state J.
REQ-024 Reset mid-packet shall abort with no EOP; the first en after release with no accepted byte keeps J.

Configuration
REQ-025 Macro USB_TX_SYNC_GEN_EN:
- Defined: every packet is preceded by an auto-generated SYNC byte 0x80 (line KJKJKJKK), and the ones counter enters DATA at 1.
- Undefined: the SYNC state is absent, the first accepted byte is sent directly, and the caller supplies SYNC as data.

Verification
REQ-026 Macro on, single byte 0x00, last=1 -> line KJKJKJKK JKJKJKJK SE0 SE0 J; tx_done pulses once; tx_error=0.
REQ-027 Macro on, byte 0xFF, last=1 -> after SYNC, K held for 5 bits, stuffed toggle to J, J held for 3 bits, then SE0 SE0 J (17 bit times after SYNC start + 3).
REQ-028 Two bytes 0x01 (last=0) then 0x80 (last=1) presented back-to-back -> no gap between bytes; the second byte is accepted while the first is shifting.
REQ-029 Byte 0x55 last=0 with no follow-on byte -> tx_error pulse after bit 7, then SE0 SE0 J, tx_done.
REQ-030 n_rst asserted mid-DATA -> dp_out=1, dm_out=0, tx_busy=0 without waiting for clk; the next packet transmits correctly.
REQ-031 Macro off, byte 0x80 last=1 -> line KJKJKJKK SE0 SE0 J.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB transmit path with holding/shift registers, NRZI encoding, bit stuffing and EOP generation.
// Define USB_TX_SYNC_GEN_EN to prefix every packet with an automatically generated SYNC byte (0x80).
module usb_tx_encoder (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

`ifdef USB_TX_SYNC_GEN_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'h80;
`else
    typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  hold_reg, hold_next;
    logic        hold_full_reg, hold_full_next;
    logic        hold_last_reg, hold_last_next;
    logic [7:0]  shift_reg, shift_next;
    logic        last_reg, last_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [2:0]  ones_reg, ones_next;
    logic        nrzi_reg, nrzi_next;
    logic        eop_cnt_reg, eop_cnt_next;
    logic        dp_reg, dp_next;
    logic        dm_reg, dm_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;

    logic        accept;
    logic        load;
    logic        send_bit;
    logic        bit_val;
    logic        level;
    logic        go_eop;

    assign tx_ready = ~hold_full_reg & (state_reg != EOP_SE0) & (state_reg != EOP_J);
    assign accept   = tx_valid & tx_ready;
    assign tx_busy  = (state_reg != IDLE);
    assign dp_out   = dp_reg;
    assign dm_out   = dm_reg;
    assign tx_done  = done_reg;
    assign tx_error = error_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
            hold_last_reg <= 1'b0;
            shift_reg     <= 8'h00;
            last_reg      <= 1'b0;
            bit_idx_reg   <= 3'd0;
            ones_reg      <= 3'd0;
            nrzi_reg      <= 1'b1;
            eop_cnt_reg   <= 1'b0;
            dp_reg        <= 1'b1;
            dm_reg        <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            hold_last_reg <= hold_last_next;
            shift_reg     <= shift_next;
            last_reg      <= last_next;
            bit_idx_reg   <= bit_idx_next;
            ones_reg      <= ones_next;
            nrzi_reg      <= nrzi_next;
            eop_cnt_reg   <= eop_cnt_next;
            dp_reg        <= dp_next;
            dm_reg        <= dm_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        hold_last_next = hold_last_reg;
        shift_next     = shift_reg;
        last_next      = last_reg;
        bit_idx_next   = bit_idx_reg;
        ones_next      = ones_reg;
        nrzi_next      = nrzi_reg;
        eop_cnt_next   = eop_cnt_reg;
        dp_next        = dp_reg;
        dm_next        = dm_reg;
        done_next      = 1'b0;
        error_next     = 1'b0;
        load           = 1'b0;
        send_bit       = 1'b0;
        bit_val        = 1'b0;
        level          = nrzi_reg;
        go_eop         = 1'b0;

        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (hold_full_reg) begin
`ifdef USB_TX_SYNC_GEN_EN
                        state_next   = SYNC;
                        bit_idx_next = 3'd0;
                        send_bit     = 1'b1;
                        bit_val      = SYNC_BYTE[0];
`else
                        load = 1'b1;
`endif
                    end
                end
`ifdef USB_TX_SYNC_GEN_EN
                SYNC: begin
                    if (bit_idx_reg == 3'd7) begin
                        load = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        send_bit     = 1'b1;
                        bit_val      = SYNC_BYTE[bit_idx_reg + 3'd1];
                    end
                end
`endif
                DATA, STUFF: begin
                    // Underrun is judged before stuffing so a starved packet goes straight to EOP.
                    if (state_reg == DATA && bit_idx_reg == 3'd7 && !last_reg && !hold_full_reg) begin
                        error_next = 1'b1;
                        go_eop     = 1'b1;
                    end else if (ones_reg == 3'd6) begin
                        state_next = STUFF;
                        send_bit   = 1'b1;
                        bit_val    = 1'b0;
                    end else if (bit_idx_reg != 3'd7) begin
                        state_next   = DATA;
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        send_bit     = 1'b1;
                        bit_val      = shift_reg[1];
                    end else if (last_reg) begin
                        go_eop = 1'b1;
                    end else if (hold_full_reg) begin
                        load = 1'b1;
                    end else begin
                        error_next = 1'b1;
                        go_eop     = 1'b1;
                    end
                end
                EOP_SE0: begin
                    if (!eop_cnt_reg) begin
                        eop_cnt_next = 1'b1;
                    end else begin
                        state_next = EOP_J;
                        dp_next    = 1'b1;
                        dm_next    = 1'b0;
                    end
                end
                EOP_J: begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    nrzi_next  = 1'b1;
                    ones_next  = 3'd0;
                end
                default: state_next = IDLE;
            endcase
        end

        if (go_eop) begin
            state_next   = EOP_SE0;
            eop_cnt_next = 1'b0;
            ones_next    = 3'd0;
            nrzi_next    = 1'b1;
            dp_next      = 1'b0;
            dm_next      = 1'b0;
        end

        if (load) begin
            state_next     = DATA;
            shift_next     = hold_reg;
            last_next      = hold_last_reg;
            hold_full_next = 1'b0;
            bit_idx_next   = 3'd0;
            send_bit       = 1'b1;
            bit_val        = hold_reg[0];
        end

        // NRZI: a 0 toggles the line, a 1 holds it; stuffed bits arrive here as 0.
        if (send_bit) begin
            level     = bit_val ? nrzi_reg : ~nrzi_reg;
            nrzi_next = level;
            ones_next = bit_val ? (ones_reg + 3'd1) : 3'd0;
            dp_next   = level;
            dm_next   = ~level;
        end

        // Written after the load so a same-cycle accept refills the register just emptied.
        if (accept) begin
            hold_next      = tx_data;
            hold_last_next = tx_last;
            hold_full_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: random and directed packets checked against a bit-stream model via a symbol scoreboard.
`timescale 1ns/1ps
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, dp_out, dm_out, tx_busy, tx_done, tx_error;

    usb_tx_encoder dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .dp_out   (dp_out),
        .dm_out   (dm_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dp;
        logic dm;
        logic err;
        logic eop;
    } sym_t;
    typedef logic [7:0] byte_q_t [$];

    sym_t exp_q[$];
    int   done_exp = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_dp = 1'b1;
    logic prev_dm = 1'b0;
    logic en_s;
    sym_t mon_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic sym_t mk(input logic dp, input logic dm, input logic err, input logic eop);
        return {dp, dm, err, eop};
    endfunction

    // Expected line symbols for one packet: raw bit stream, stuff after six 1s, NRZI from J, then EOP.
    task automatic push_packet(input byte_q_t bytes, input bit underrun);
        bit         bits[$];
        logic [7:0] b;
        int         ones;
        logic       lvl;
`ifdef USB_TX_SYNC_GEN_EN
        b = 8'h80;
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`endif
        foreach (bytes[k]) begin
            b = bytes[k];
            for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        end
        ones = 0;
        lvl  = 1'b1;
        for (int k = 0; k < bits.size(); k++) begin
            if (bits[k]) ones++;
            else begin
                ones = 0;
                lvl  = ~lvl;
            end
            exp_q.push_back(mk(lvl, ~lvl, 1'b0, 1'b0));
            if (ones == 6 && !(underrun && k == bits.size() - 1)) begin
                ones = 0;
                lvl  = ~lvl;
                exp_q.push_back(mk(lvl, ~lvl, 1'b0, 1'b0));
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, underrun, 1'b1));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
        done_exp++;
    endtask

    task automatic send_packet(input byte_q_t bytes, input bit last_flag);
        int t;
        push_packet(bytes, !last_flag);
        foreach (bytes[k]) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = bytes[k];
            tx_last  = (k == bytes.size() - 1) ? last_flag : 1'b0;
            t = 0;
            while (!tx_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!tx_ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte=%0h ready=%0b required=1", bytes[k], tx_ready);
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_exp != 0 || tx_busy) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("pending_symbols", exp_q.size(), 0);
        check("pending_done", done_exp, 0);
        exp_q.delete();
        done_exp = 0;
        repeat (3) @(negedge clk);
    endtask

    // Bit-time strobe with random spacing.
    initial begin
        forever begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
        end
    end

    // Monitor: one symbol popped per strobe while busy; quiet outputs between strobes.
    initial begin
        forever begin
            @(posedge clk);
            en_s = en;
            #1;
            if (!n_rst) begin
                prev_dp = 1'b1;
                prev_dm = 1'b0;
            end else if (!en_s) begin
                check("hold_dp", dp_out, prev_dp);
                check("hold_dm", dm_out, prev_dm);
                check("done_between", tx_done, 0);
                check("error_between", tx_error, 0);
            end else if (tx_busy) begin
                check("done_busy", tx_done, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_symbol dp=%0b dm=%0b required=none", dp_out, dm_out);
                end else begin
                    mon_s = exp_q.pop_front();
                    check("line_dp", dp_out, mon_s.dp);
                    check("line_dm", dm_out, mon_s.dm);
                    check("tx_error", tx_error, mon_s.err);
                    if (mon_s.eop) check("ready_in_eop", tx_ready, 0);
                end
            end else begin
                check("idle_dp", dp_out, 1);
                check("idle_dm", dm_out, 0);
                check("idle_error", tx_error, 0);
                if (tx_done) begin
                    if (done_exp == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done done=1 required=0");
                    end else begin
                        done_exp--;
                    end
                end
            end
            prev_dp = dp_out;
            prev_dm = dm_out;
        end
    end

    initial begin
        byte_q_t     q;
        logic [31:0] r;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_dp", dp_out, 1);
        check("rst_dm", dm_out, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);

        q = '{8'h00};               send_packet(q, 1'b1); wait_idle();
        q = '{8'hFF};               send_packet(q, 1'b1); wait_idle();
        q = '{8'h01, 8'h80};        send_packet(q, 1'b1); wait_idle();
        q = '{8'h55};               send_packet(q, 1'b0); wait_idle();
        q = '{8'h80};               send_packet(q, 1'b1); wait_idle();
        q = '{8'hFC};               send_packet(q, 1'b1); wait_idle();
        q = '{8'hE0, 8'h07};        send_packet(q, 1'b1); wait_idle();
        q = '{8'hFC};               send_packet(q, 1'b0); wait_idle();
        q = '{8'h7E, 8'hFF, 8'h03}; send_packet(q, 1'b1); wait_idle();

        for (int p = 0; p < 16; p++) begin
            q = {};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                r = $urandom;
                q.push_back((r[9:8] == 2'd0) ? 8'hFF : r[7:0]);
            end
            send_packet(q, ($urandom_range(0, 4) != 0));
            wait_idle();
        end

        // Abort mid-packet with an asynchronous reset, then confirm recovery.
        q = '{8'hA5, 8'h3C};
        send_packet(q, 1'b1);
        repeat (6) @(posedge en);
        @(negedge clk);
        check("busy_before_reset", tx_busy, 1);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        done_exp = 0;
        #1;
        check("async_rst_dp", dp_out, 1);
        check("async_rst_dm", dm_out, 0);
        check("async_rst_busy", tx_busy, 0);
        check("async_rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", tx_busy, 0);
        q = '{8'h00};        send_packet(q, 1'b1); wait_idle();
        q = '{8'hC3, 8'hFF}; send_packet(q, 1'b1); wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
